// File: rtl/lsu_ctrl.sv
// Load/store unit controller: computes the effective address, checks alignment and runs one SRAM-like bus op.
// Latency: an aligned op goes accept -> ADDR -> DATA -> RESP; a misaligned op goes accept -> RESP.
// Backpressure: req_ready is high only in IDLE with no flush; the bus throttles us through data_addr_ok and data_data_ok.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] base,
  input  logic [31:0] imm_ext,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  op_q;
  logic        fault_q;
  logic [31:0] addr_sum;
  logic        accept, misalign;

  // Access width encoding shared by the bus size field and the alignment check.
  function automatic logic [1:0] size_of(input logic [2:0] o);
    case (o)
      3'b000, 3'b001, 3'b101: size_of = 2'd0;
      3'b010, 3'b011, 3'b110: size_of = 2'd1;
      default:                size_of = 2'd2;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] o);
    is_store = o[2] & (o[1] | o[0]);
  endfunction

  // Stores replicate the narrow value across every lane; loads put nothing on the write bus.
  function automatic logic [31:0] replicate(input logic [2:0] o, input logic [31:0] w);
    case (o)
      3'b101:  replicate = {4{w[7:0]}};
      3'b110:  replicate = {2{w[15:0]}};
      3'b111:  replicate = w;
      default: replicate = 32'd0;
    endcase
  endfunction

  // Pick the addressed lane of the bus word and sign- or zero-extend it; stores return zero.
  function automatic logic [31:0] load_ext(input logic [2:0] o, input logic [1:0] lane,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (o)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {24'd0, b};
      3'b010:  load_ext = {{16{h[15]}}, h};
      3'b011:  load_ext = {16'd0, h};
      3'b100:  load_ext = d;
      default: load_ext = 32'd0;
    endcase
  endfunction

  assign addr_sum = base + imm_ext;
  assign misalign = ((size_of(op) == 2'd1) && addr_sum[0]) ||
                    ((size_of(op) == 2'd2) && (addr_sum[1:0] != 2'b00));
  assign accept   = req_valid && req_ready;

  // State register; reset drops any in-flight transaction on the spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: flush can only abort before the address handshake has completed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misalign ? RESP : ADDR;
      ADDR: begin
        if (data_addr_ok) state_nxt = DATA;
        else if (flush)   state_nxt = IDLE;
      end
      DATA: if (data_data_ok) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the op on accept and the extended load data on the data handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      op_q    <= 3'd0;
      fault_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_sum;
      wdata_q <= replicate(op, wdata);
      rdata_q <= 32'd0;
      op_q    <= op;
      fault_q <= misalign;
    end else if (state == DATA && data_data_ok) begin
      rdata_q <= load_ext(op_q, addr_q[1:0], data_rdata);
    end
  end

  // Outputs are zero outside the phase that owns them, so reset values fall out of the IDLE state.
  always_comb begin
    req_ready  = (state == IDLE) && !flush;
    resp_valid = 1'b0;
    rdata      = 32'd0;
    adel       = 1'b0;
    ades       = 1'b0;
    badvaddr   = 32'd0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    case (state)
      ADDR: begin
        data_req   = 1'b1;
        data_wr    = is_store(op_q);
        data_size  = size_of(op_q);
        data_addr  = addr_q;
        data_wdata = wdata_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        rdata      = rdata_q;
        adel       = fault_q && !is_store(op_q);
        ades       = fault_q && is_store(op_q);
        badvaddr   = fault_q ? addr_q : 32'd0;
      end
      default: ;
    endcase
  end

endmodule
